// File: rtl/engine_stride_index_multi_channel_pkg.sv
// Shared types for the multi-channel stride index engine: FSM state encoding,
// the default-geometry job configuration record and a channel-index width helper.
package engine_stride_index_multi_channel_pkg;

  localparam int SI_NUM_CHANNELS = 4;
  localparam int SI_ADDR_WIDTH   = 32;
  localparam int SI_META_WIDTH   = 32;

  typedef enum logic [2:0] {
    MC_RESET,
    MC_IDLE,
    MC_SETUP,
    MC_START,
    MC_BUSY,
    MC_PAUSE,
    MC_DONE
  } engine_stride_index_mc_state;

  // Job layout at the default geometry; the engine mirrors it at its own widths.
  typedef struct packed {
    logic                       increment;
    logic                       decrement;
    logic [SI_ADDR_WIDTH-1:0]   index_start;
    logic [SI_ADDR_WIDTH-1:0]   index_end;
    logic [SI_ADDR_WIDTH-1:0]   stride;
    logic [SI_ADDR_WIDTH-1:0]   granularity;
    logic [SI_META_WIDTH-1:0]   meta;
    logic [SI_NUM_CHANNELS-1:0] chan_enable;
  } StrideIndexMCConfiguration;

  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/engine_stride_index_rr_select.sv
// Finds the next enabled channel after i_cur_ch, wrapping NUM_CHANNELS-1 -> 0.
// If nothing else is enabled the current channel is returned.
module engine_stride_index_rr_select
  import engine_stride_index_multi_channel_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  localparam int CH_W = chan_width(NUM_CHANNELS)
) (
  input  logic [CH_W-1:0]         i_cur_ch,
  input  logic [NUM_CHANNELS-1:0] i_enable,
  output logic [CH_W-1:0]         o_next_ch
);

  logic [CH_W:0]           w_shamt;
  logic [NUM_CHANNELS-1:0] w_rot;

  // Bit k of w_rot is the enable of channel (cur + 1 + k) mod NUM_CHANNELS.
  assign w_shamt = {1'b0, i_cur_ch} + {{CH_W{1'b0}}, 1'b1};
  assign w_rot   = NUM_CHANNELS'({i_enable, i_enable} >> w_shamt);

  always_comb begin : find_next
    int nxt;
    o_next_ch = i_cur_ch;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      nxt = (int'(i_cur_ch) + 1 + k) % NUM_CHANNELS;
      if (w_rot[k]) o_next_ch = CH_W'(nxt);
    end
  end

endmodule

// File: rtl/engine_stride_index_multi_channel.sv
// Stride index generator dealing chunks of 'granularity' indices round-robin over
// NUM_CHANNELS valid/ready channels, with enable mask, pause and wrap-safe termination.
module engine_stride_index_multi_channel
  import engine_stride_index_multi_channel_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int META_WIDTH   = 32
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst_n,
  input  logic                           cfg_valid,
  input  logic                           cfg_increment,
  input  logic                           cfg_decrement,
  input  logic [ADDR_WIDTH-1:0]          cfg_index_start,
  input  logic [ADDR_WIDTH-1:0]          cfg_index_end,
  input  logic [ADDR_WIDTH-1:0]          cfg_stride,
  input  logic [ADDR_WIDTH-1:0]          cfg_granularity,
  input  logic [META_WIDTH-1:0]          cfg_meta,
  input  logic [NUM_CHANNELS-1:0]        chan_enable,
  input  logic                           pause_in,
  output logic [NUM_CHANNELS-1:0]        out_valid,
  output logic [NUM_CHANNELS*ADDR_WIDTH-1:0] out_index,
  output logic [META_WIDTH-1:0]          out_meta,
  input  logic [NUM_CHANNELS-1:0]        out_ready,
  output logic                           busy_out,
  output logic                           done_out,
  output logic                           error_out
);

  localparam int CH_W = chan_width(NUM_CHANNELS);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

  typedef struct packed {
    logic                    increment;
    logic                    decrement;
    logic [ADDR_WIDTH-1:0]   index_start;
    logic [ADDR_WIDTH-1:0]   index_end;
    logic [ADDR_WIDTH-1:0]   stride;
    logic [ADDR_WIDTH-1:0]   granularity;
    logic [META_WIDTH-1:0]   meta;
    logic [NUM_CHANNELS-1:0] chan_enable;
  } job_t;

  engine_stride_index_mc_state r_state;
  job_t                        r_job;
  logic [ADDR_WIDTH-1:0]       r_idx;
  logic [ADDR_WIDTH-1:0]       r_cnt;
  logic [CH_W-1:0]             r_cur_ch;
  logic [NUM_CHANNELS-1:0]     r_valid;
  logic [ADDR_WIDTH-1:0]       r_index [NUM_CHANNELS];
  logic                        r_pause_req;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_error;

  logic [CH_W-1:0]       w_rr_cur;
  logic [CH_W-1:0]       w_rr_next;
  logic [CH_W-1:0]       w_ch_after;
  logic [ADDR_WIDTH:0]   w_step;
  logic [ADDR_WIDTH-1:0] w_next_idx;
  logic [ADDR_WIDTH-1:0] w_gran;
  logic [ADDR_WIDTH-1:0] w_cnt_inc;
  logic [ADDR_WIDTH-1:0] w_cnt_after;
  logic                  w_last;
  logic                  w_accept;
  logic                  w_chunk_end;
  logic                  w_cfg_err;
  logic                  w_empty;

  // In START the search begins "after" the last channel so the lowest enabled one wins.
  assign w_rr_cur = (r_state == MC_START) ? LAST_CH : r_cur_ch;

  engine_stride_index_rr_select #(
    .NUM_CHANNELS (NUM_CHANNELS)
  ) u_rr_select (
    .i_cur_ch  (w_rr_cur),
    .i_enable  (r_job.chan_enable),
    .o_next_ch (w_rr_next)
  );

  assign w_step = r_job.increment ? ({1'b0, r_idx} + {1'b0, r_job.stride})
                                  : ({1'b0, r_idx} - {1'b0, r_job.stride});
  assign w_next_idx = w_step[ADDR_WIDTH-1:0];
  // The top bit is carry (ascending) or borrow (descending): either ends the job.
  assign w_last = w_step[ADDR_WIDTH] |
                  (r_job.increment ? (w_next_idx >= r_job.index_end)
                                   : (w_next_idx <= r_job.index_end));

  assign w_gran      = (r_job.granularity == '0) ? ADDR_WIDTH'(1) : r_job.granularity;
  assign w_cnt_inc   = r_cnt + ADDR_WIDTH'(1);
  assign w_chunk_end = (w_cnt_inc >= w_gran);
  assign w_cnt_after = w_chunk_end ? '0 : w_cnt_inc;
  assign w_ch_after  = w_chunk_end ? w_rr_next : r_cur_ch;
  assign w_accept    = r_valid[r_cur_ch] & out_ready[r_cur_ch];

  assign w_cfg_err = (r_job.increment == r_job.decrement) | (r_job.stride == '0) |
                     (r_job.chan_enable == '0);
  assign w_empty   = r_job.increment ? (r_job.index_start >= r_job.index_end)
                                     : (r_job.index_start <= r_job.index_end);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state     <= MC_RESET;
      r_job       <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_cur_ch    <= '0;
      r_valid     <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) r_index[c] <= '0;
      r_pause_req <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        MC_RESET: r_state <= MC_IDLE;
        MC_IDLE, MC_DONE: begin
          if (cfg_valid) begin
            r_job.increment   <= cfg_increment;
            r_job.decrement   <= cfg_decrement;
            r_job.index_start <= cfg_index_start;
            r_job.index_end   <= cfg_index_end;
            r_job.stride      <= cfg_stride;
            r_job.granularity <= cfg_granularity;
            r_job.meta        <= cfg_meta;
            r_state           <= MC_SETUP;
            r_busy            <= 1'b1;
            r_done            <= 1'b0;
            r_error           <= 1'b0;
          end
        end
        MC_SETUP: begin
          r_job.chan_enable <= chan_enable;
          r_state           <= MC_START;
        end
        MC_START: begin
          if (w_cfg_err || w_empty) begin
            r_state <= MC_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_error <= w_cfg_err;
          end else begin
            r_state             <= MC_BUSY;
            r_idx               <= r_job.index_start;
            r_cnt               <= '0;
            r_cur_ch            <= w_rr_next;
            r_valid             <= NUM_CHANNELS'(1) << w_rr_next;
            r_index[w_rr_next]  <= r_job.index_start;
            r_pause_req         <= 1'b0;
          end
        end
        MC_BUSY: begin
          if (w_accept) begin
            if (w_last) begin
              r_valid     <= '0;
              r_state     <= MC_DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_pause_req <= 1'b0;
            end else begin
              r_idx    <= w_next_idx;
              r_cnt    <= w_cnt_after;
              r_cur_ch <= w_ch_after;
              if (pause_in || r_pause_req) begin
                r_valid     <= '0;
                r_state     <= MC_PAUSE;
                r_pause_req <= 1'b0;
              end else begin
                r_valid             <= NUM_CHANNELS'(1) << w_ch_after;
                r_index[w_ch_after] <= w_next_idx;
              end
            end
          end else if (pause_in) begin
            r_pause_req <= 1'b1;
          end
        end
        MC_PAUSE: begin
          if (!pause_in) begin
            r_state           <= MC_BUSY;
            r_valid           <= NUM_CHANNELS'(1) << r_cur_ch;
            r_index[r_cur_ch] <= r_idx;
          end
        end
        default: r_state <= MC_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_out_index
    assign out_index[gi*ADDR_WIDTH +: ADDR_WIDTH] = r_index[gi];
  end

  assign out_valid = r_valid;
  assign out_meta  = r_job.meta;
  assign busy_out  = r_busy;
  assign done_out  = r_done;
  assign error_out = r_error;

endmodule

// File: tb/tb_engine_stride_index_multi_channel.sv
// Directed and randomized jobs checked beat-by-beat against an arithmetic model of the
// index sequence and its round-robin chunk dealing over the enabled channels.
module tb_engine_stride_index_multi_channel;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_inc;
  logic        cfg_dec;
  logic [7:0]  cfg_start;
  logic [7:0]  cfg_end;
  logic [7:0]  cfg_stride;
  logic [7:0]  cfg_gran;
  logic [15:0] cfg_meta;
  logic [3:0]  chan_en;
  logic        pause;
  logic [3:0]  out_valid;
  logic [31:0] out_index;
  logic [15:0] out_meta;
  logic [3:0]  out_ready;
  logic        busy;
  logic        done;
  logic        err;

  int n_vec = 0;
  int n_mis = 0;

  engine_stride_index_multi_channel #(
    .NUM_CHANNELS (4),
    .ADDR_WIDTH   (8),
    .META_WIDTH   (16)
  ) dut (
    .ap_clk          (clk),
    .ap_rst_n        (rst_n),
    .cfg_valid       (cfg_valid),
    .cfg_increment   (cfg_inc),
    .cfg_decrement   (cfg_dec),
    .cfg_index_start (cfg_start),
    .cfg_index_end   (cfg_end),
    .cfg_stride      (cfg_stride),
    .cfg_granularity (cfg_gran),
    .cfg_meta        (cfg_meta),
    .chan_enable     (chan_en),
    .pause_in        (pause),
    .out_valid       (out_valid),
    .out_index       (out_index),
    .out_meta        (out_meta),
    .out_ready       (out_ready),
    .busy_out        (busy),
    .done_out        (done),
    .error_out       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one job from a negedge in IDLE/DONE; mode 0 = ready held high,
  // 1 = random ready, 2 = 5-cycle stall with a pause pulse after the second accept.
  task automatic run_job(input string name, input bit inc, input bit dec, input int start,
                         input int stop, input int stride, input int gran,
                         input logic [3:0] en, input int mode);
    int exp_idx[$];
    int exp_ch[$];
    int ens[$];
    bit exp_err;
    int g, k, v, n_exp, n_acc, cyc, first_cyc, last_acc_cyc, stall_left, ch, idx;
    bit stall_done, expect_gap, gap_next, prev_held;
    logic [3:0]  prev_valid;
    int          prev_idx;
    logic [15:0] meta;
    logic [31:0] r;

    meta    = 16'($urandom);
    exp_err = (inc == dec) || (stride == 0) || (en == 4'b0);
    g       = (gran == 0) ? 1 : gran;
    if (!exp_err) begin
      for (int c = 0; c < 4; c++) if (en[c]) ens.push_back(c);
      k = 0;
      if (inc) begin
        for (v = start; v < stop; v += stride) begin
          exp_idx.push_back(v);
          exp_ch.push_back(ens[(k / g) % ens.size()]);
          k++;
        end
      end else begin
        for (v = start; v > stop; v -= stride) begin
          exp_idx.push_back(v);
          exp_ch.push_back(ens[(k / g) % ens.size()]);
          k++;
        end
      end
    end
    n_exp = exp_idx.size();

    cfg_inc    = inc;
    cfg_dec    = dec;
    cfg_start  = 8'(start);
    cfg_end    = 8'(stop);
    cfg_stride = 8'(stride);
    cfg_gran   = 8'(gran);
    cfg_meta   = meta;
    chan_en    = en;
    cfg_valid  = 1'b1;
    @(negedge clk);
    cfg_valid  = 1'b0;
    cfg_inc    = 1'($urandom);
    cfg_dec    = 1'($urandom);
    cfg_start  = 8'($urandom);
    cfg_end    = 8'($urandom);
    cfg_stride = 8'($urandom);
    cfg_gran   = 8'($urandom);
    cfg_meta   = 16'($urandom);

    n_acc = 0; cyc = 0; first_cyc = -1; last_acc_cyc = -1; stall_left = 0; ch = 0;
    stall_done = 0; expect_gap = 0; gap_next = 0; prev_held = 0; prev_valid = '0; prev_idx = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      check({name, " onehot"}, 32'(out_valid & (out_valid - 4'd1)), 32'd0);
      check({name, " disabled_ch"}, 32'(out_valid & ~en), 32'd0);
      if (n_exp == 0) check({name, " no_beat"}, 32'(out_valid), 32'd0);
      for (int c = 3; c >= 0; c--) if (out_valid[c]) ch = c;
      idx = int'(8'(out_index >> (ch * 8)));
      if (prev_held) begin
        check({name, " hold_valid"}, 32'(out_valid), 32'(prev_valid));
        check({name, " hold_index"}, idx, prev_idx);
      end
      if (gap_next) begin
        check({name, " pause_gap"}, 32'(out_valid), 32'd0);
        gap_next = 0;
      end
      pause = 1'b0;
      case (mode)
        0: out_ready = 4'hf;
        1: begin
          r = $urandom;
          out_ready = 4'(r) | 4'(r >> 4);
        end
        default: begin
          if (n_acc == 2 && !stall_done) begin
            if (stall_left == 0) begin
              stall_left = 5;
              pause      = 1'b1;
              expect_gap = 1;
            end
            out_ready = 4'h0;
            stall_left--;
            if (stall_left == 0) stall_done = 1;
          end else begin
            out_ready = 4'hf;
          end
        end
      endcase
      if (out_valid != 4'h0) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (((out_ready >> ch) & 4'd1) != 4'd0) begin
          if (exp_idx.size() == 0) begin
            check({name, " extra_beat"}, n_acc + 1, n_exp);
          end else begin
            check({name, " channel"}, ch, exp_ch.pop_front());
            check({name, " index"}, idx, exp_idx.pop_front());
          end
          n_acc++;
          last_acc_cyc = cyc;
          prev_held    = 0;
          if (expect_gap && exp_idx.size() != 0) begin
            gap_next   = 1;
            expect_gap = 0;
          end
        end else begin
          prev_held  = 1;
          prev_valid = out_valid;
          prev_idx   = idx;
        end
      end else begin
        prev_held = 0;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 4'h0;
    pause     = 1'b0;
    check({name, " done_within_budget"}, 32'(done), 32'd1);
    check({name, " error"}, 32'(err), 32'(exp_err));
    check({name, " beat_count"}, n_acc, n_exp);
    check({name, " busy_at_done"}, 32'(busy), 32'd0);
    check({name, " valid_at_done"}, 32'(out_valid), 32'd0);
    check({name, " meta"}, 32'(out_meta), 32'(meta));
    if (n_exp > 0) check({name, " done_latency"}, cyc - last_acc_cyc, 1);
    if (mode == 0 && n_exp > 0) check({name, " full_rate"}, cyc - first_cyc, n_exp);
    $display("job %s: inc=%0b dec=%0b start=%0d end=%0d stride=%0d gran=%0d en=%b beats=%0d/%0d err=%0b",
             name, inc, dec, start, stop, stride, gran, en, n_acc, n_exp, err);
  endtask

  initial begin
    int sel, s, e, st, gr;
    bit ri, rd;
    logic [3:0] ren;

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_inc = 1'b0; cfg_dec = 1'b0; cfg_start = '0;
    cfg_end = '0; cfg_stride = '0; cfg_gran = '0; cfg_meta = '0; chan_en = '0;
    pause = 1'b0; out_ready = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset valid", 32'(out_valid), 32'd0);
    check("reset index", out_index, 32'd0);
    check("reset meta", 32'(out_meta), 32'd0);
    check("reset flags", 32'({busy, done, err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle flags", 32'({busy, done, err}), 32'd0);

    run_job("t1_inc_gran2", 1, 0, 0, 8, 1, 2, 4'b1111, 0);
    run_job("t2_dec_2ch", 0, 1, 10, 0, 3, 1, 4'b0011, 0);
    run_job("t3_carry", 1, 0, 250, 255, 4, 1, 4'b1111, 0);
    run_job("t4_mask0101", 1, 0, 0, 7, 1, 3, 4'b0101, 0);
    run_job("t5_stall_pause", 1, 0, 0, 12, 1, 4, 4'b1111, 2);
    run_job("t6_incdec", 1, 1, 0, 8, 1, 1, 4'b1111, 0);
    run_job("t6_stride0", 1, 0, 0, 8, 0, 1, 4'b1111, 0);
    run_job("mask_zero", 0, 1, 9, 1, 2, 1, 4'b0000, 0);
    run_job("empty_inc", 1, 0, 9, 9, 2, 1, 4'b1111, 0);
    run_job("dec_borrow", 0, 1, 5, 0, 7, 0, 4'b1000, 0);

    for (int j = 0; j < 24; j++) begin
      sel = $urandom_range(0, 9);
      ri  = (sel == 0) ? 1'b1 : (sel == 1) ? 1'b0 : ((sel % 2) == 0);
      rd  = (sel == 0) ? 1'b1 : (sel == 1) ? 1'b0 : !ri;
      s   = $urandom_range(0, 255);
      e   = $urandom_range(0, 255);
      st  = $urandom_range(0, 12);
      gr  = $urandom_range(0, 5);
      ren = 4'($urandom_range(0, 15));
      run_job($sformatf("rand%0d", j), ri, rd, s, e, st, gr, ren, 1);
    end

    cfg_inc = 1'b1; cfg_dec = 1'b0; cfg_start = 8'd0; cfg_end = 8'd200; cfg_stride = 8'd1;
    cfg_gran = 8'd2; cfg_meta = 16'h5a5a; chan_en = 4'b1111; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    out_ready = 4'hf;
    repeat (6) @(negedge clk);
    check("mid_busy busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst valid", 32'(out_valid), 32'd0);
    check("async_rst index", out_index, 32'd0);
    check("async_rst meta", 32'(out_meta), 32'd0);
    check("async_rst flags", 32'({busy, done, err}), 32'd0);
    $display("job async_reset: outputs valid=%b busy=%0b done=%0b", out_valid, busy, done);
    out_ready = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    run_job("after_reset", 1, 0, 3, 20, 5, 1, 4'b0110, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
